conv_frame_sequencer: RTL and testbench

Frame-level scheduler that drives the convolution controller's command inputs (`coeff_load_en`, `sample_load_en`, `new_row`) over a whole image. It accepts column samples from an upstream source through a valid/ready handshake and issues one load command per sample. It paces commands against the controller's `modwait` and marks row boundaries. It sits between the host/stream source and the convolution controller and tracks column/row position for the output side.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_frame_sequencer_flex_counter.sv | 32 +++
 rtl/conv_frame_sequencer.sv | 167 ++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution frame sequencer.
// Optional abort input is enabled with CONV_SEQ_ABORT_EN (see conv_frame_sequencer).
package conv_pkg;

    localparam int SEQ_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        COEFF,
        ACCEPT,
        ISSUE,
        WAIT,
        ROW,
        DONE
    } seq_state_t;

    // Where WAIT goes once the controller is no longer busy
    typedef enum logic [1:0] {
        RET_ACCEPT,
        RET_ROW,
        RET_DONE
    } wait_ret_t;

endpackage

// File: rtl/conv_frame_sequencer_flex_counter.sv
// Up-counter with synchronous clear and wrap at a programmable rollover value.
module flex_counter
    import conv_pkg::*;
#(
    parameter int WIDTH = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= '0;
            end else begin
                count_out <= count_out + WIDTH'(1);
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame scheduler issuing coefficient/sample/row commands to the convolution controller.
// Define CONV_SEQ_ABORT_EN to add the abort input that ends a frame early.
//
// state  | meaning
// IDLE   | waiting for start; counters hold last frame position
// COEFF  | coeff_load_en pulse
// ACCEPT | src_ready = !modwait, waiting for a sample handshake
// ISSUE  | sample_load_en pulse, column advance
// WAIT   | pacing against modwait (first cycle never exits)
// ROW    | new_row pulse, column clear, row advance
// DONE   | frame_done pulse
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int NUM_COLS = 8,
    parameter int NUM_ROWS = 6
) (
    input  logic                 clk,
    input  logic                 n_rst,
`ifdef CONV_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic                 reload_coeff,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic                 modwait,
    output logic                 coeff_load_en,
    output logic                 sample_load_en,
    output logic                 new_row,
    output logic [SEQ_CNT_W-1:0] col_idx,
    output logic [SEQ_CNT_W-1:0] row_idx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [SEQ_CNT_W-1:0] COL_LAST = SEQ_CNT_W'(NUM_COLS - 1);
    localparam logic [SEQ_CNT_W-1:0] ROW_LAST = SEQ_CNT_W'(NUM_ROWS - 1);

    seq_state_t state;
    seq_state_t nxt;
    wait_ret_t  ret;
    wait_ret_t  ret_nxt;
    logic       wait_first;
    logic       abort_req;
    logic       col_last;
    logic       row_last;
    logic       col_clr;
    logic       col_en;
    logic       row_clr;
    logic       row_en;

`ifdef CONV_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        ret_nxt = ret;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt = reload_coeff ? COEFF : ACCEPT;
                end
            end
            COEFF: begin
                nxt     = WAIT;
                ret_nxt = RET_ACCEPT;
            end
            ACCEPT: begin
                if (src_valid && !modwait) begin
                    nxt = ISSUE;
                end
            end
            ISSUE: begin
                nxt = WAIT;
                if (!col_last) begin
                    ret_nxt = RET_ACCEPT;
                end else if (row_last) begin
                    ret_nxt = RET_DONE;
                end else begin
                    ret_nxt = RET_ROW;
                end
            end
            WAIT: begin
                // modwait lags the command by a cycle, so the first WAIT cycle never exits
                if (!wait_first && !modwait) begin
                    case (ret)
                        RET_ROW:  nxt = ROW;
                        RET_DONE: nxt = DONE;
                        default:  nxt = ACCEPT;
                    endcase
                end
            end
            ROW: begin
                nxt     = WAIT;
                ret_nxt = RET_ACCEPT;
            end
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
        if (abort_req && (state != IDLE) && (state != DONE)) begin
            nxt = DONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            ret            <= RET_ACCEPT;
            wait_first     <= 1'b0;
            coeff_load_en  <= 1'b0;
            sample_load_en <= 1'b0;
            new_row        <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            state          <= nxt;
            ret            <= ret_nxt;
            wait_first     <= (nxt == WAIT) && (state != WAIT);
            coeff_load_en  <= (nxt == COEFF);
            sample_load_en <= (nxt == ISSUE);
            new_row        <= (nxt == ROW);
            busy           <= (nxt != IDLE);
            frame_done     <= (nxt == DONE);
        end
    end

    assign src_ready = (state == ACCEPT) && !modwait;

    // An abort freezes both counters at the position reached so far
    assign col_clr = ((state == IDLE) && start) || ((state == ROW) && !abort_req);
    assign col_en  = (state == ISSUE) && !col_last && !abort_req;
    assign row_clr = (state == IDLE) && start;
    assign row_en  = (state == ROW) && !abort_req;

    flex_counter #(
        .WIDTH(SEQ_CNT_W)
    ) u_col_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (col_clr),
        .count_enable (col_en),
        .rollover_val (COL_LAST),
        .count_out    (col_idx),
        .rollover_flag(col_last)
    );

    flex_counter #(
        .WIDTH(SEQ_CNT_W)
    ) u_row_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (row_clr),
        .count_enable (row_en),
        .rollover_val (ROW_LAST),
        .count_out    (row_idx),
        .rollover_flag(row_last)
    );

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer with a simple convolution-controller model.
// Abort scenario is exercised only when CONV_SEQ_ABORT_EN is defined.
module tb_conv_frame_sequencer;

    localparam int NC = 4;
    localparam int NR = 3;
    localparam int NS = NC * NR;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       reload_coeff;
    logic       src_valid;
    logic       src_ready;
    logic       modwait;
    logic       coeff_load_en;
    logic       sample_load_en;
    logic       new_row;
    logic [7:0] col_idx;
    logic [7:0] row_idx;
    logic       busy;
    logic       frame_done;
`ifdef CONV_SEQ_ABORT_EN
    logic       abort;
`endif

    conv_frame_sequencer #(
        .NUM_COLS(NC),
        .NUM_ROWS(NR)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
`ifdef CONV_SEQ_ABORT_EN
        .abort         (abort),
`endif
        .start         (start),
        .reload_coeff  (reload_coeff),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .modwait       (modwait),
        .coeff_load_en (coeff_load_en),
        .sample_load_en(sample_load_en),
        .new_row       (new_row),
        .col_idx       (col_idx),
        .row_idx       (row_idx),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller model: busy 3 cycles after a coefficient load, 0..3 cycles after a sample
    logic force_wait;
    int   busy_cnt;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy_cnt <= 0;
        end else if (coeff_load_en) begin
            busy_cnt <= 3;
        end else if (sample_load_en) begin
            busy_cnt <= int'($urandom_range(0, 3));
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign modwait = force_wait || (busy_cnt != 0);

    int tests = 0;
    int fails = 0;

    int issued[$];
    int row_marks[$];
    int cur_id, prev_id;
    bit prev_hs;
    int n_ovl, n_done, n_coeff, seq_err;

    task automatic clear_stats();
        issued.delete();
        row_marks.delete();
        cur_id  = 0;
        prev_id = 0;
        prev_hs = 0;
        n_ovl   = 0;
        n_done  = 0;
        n_coeff = 0;
        seq_err = 0;
    endtask

    // Drives one frame (optionally starting it) and records what the DUT issued
    task automatic run_frame(input bit do_start, input bit reload, input int mode, input int max_cyc);
        bit hs;
        if (do_start) begin
            clear_stats();
            @(posedge clk); #1;
            start = 1'b1; reload_coeff = reload;
            @(posedge clk); #1;
            start = 1'b0; reload_coeff = 1'b0;
        end
        for (int c = 0; c < max_cyc; c++) begin
            case (mode)
                0:       src_valid = 1'b1;
                1:       src_valid = ~src_valid;
                default: begin
                    src_valid = 1'($urandom_range(0, 1));
                    start     = ($urandom_range(0, 3) == 0);
                end
            endcase
            @(negedge clk);
            hs = src_valid && src_ready;
            if (sample_load_en) begin
                issued.push_back(prev_id);
                if (!prev_hs) seq_err++;
            end else if (prev_hs) begin
                seq_err++;
            end
            if (new_row) begin
                row_marks.push_back(issued.size());
                if (sample_load_en) n_ovl++;
            end
            if (coeff_load_en) n_coeff++;
            if (frame_done) n_done++;
            if (hs) begin
                prev_id = cur_id;
                cur_id++;
            end
            prev_hs = hs;
            @(posedge clk); #1;
            if (n_done != 0) break;
        end
        src_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #1;
        tests++;
        if ({src_ready, coeff_load_en, sample_load_en, new_row, busy, frame_done} !== 6'b0 ||
            col_idx !== 8'd0 || row_idx !== 8'd0) begin
            fails++;
            $display("FAIL reset_init: outputs ctl=%b col=%0d row=%0d, want all 0",
                     {src_ready, coeff_load_en, sample_load_en, new_row, busy, frame_done}, col_idx, row_idx);
        end
        @(negedge clk); n_rst = 1'b1;
        // start a frame and pull reset part way through
        @(posedge clk); #1; start = 1'b1; src_valid = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        tests++;
        if ({src_ready, coeff_load_en, sample_load_en, new_row, busy, frame_done} !== 6'b0 ||
            col_idx !== 8'd0 || row_idx !== 8'd0) begin
            fails++;
            $display("FAIL reset_midframe: outputs ctl=%b col=%0d row=%0d, want all 0",
                     {src_ready, coeff_load_en, sample_load_en, new_row, busy, frame_done}, col_idx, row_idx);
        end
        src_valid = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || src_ready !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle: busy=%b src_ready=%b, want 0 0", busy, src_ready);
            end
        end
    endtask

    task automatic test_full_frame(input int mode, input string tag);
        run_frame(1, 0, mode, 2000);
        tests++;
        if (n_done != 1) begin
            fails++;
            $display("FAIL %s_done: frame_done pulses %0d, want 1", tag, n_done);
        end
        tests++;
        if (issued.size() != NS) begin
            fails++;
            $display("FAIL %s_count: samples %0d, want %0d", tag, issued.size(), NS);
        end
        for (int i = 0; i < issued.size() && i < NS; i++) begin
            tests++;
            if (issued[i] != i) begin
                fails++;
                $display("FAIL %s_order: slot %0d got sample %0d, want %0d", tag, i, issued[i], i);
            end
        end
        tests++;
        if (cur_id != NS || seq_err != 0) begin
            fails++;
            $display("FAIL %s_handshake: accepted %0d, pairing errors %0d, want %0d and 0", tag, cur_id, seq_err, NS);
        end
        tests++;
        if (row_marks.size() != NR - 1) begin
            fails++;
            $display("FAIL %s_rows: new_row pulses %0d, want %0d", tag, row_marks.size(), NR - 1);
        end
        for (int i = 0; i < row_marks.size() && i < NR - 1; i++) begin
            tests++;
            if (row_marks[i] != (i + 1) * NC) begin
                fails++;
                $display("FAIL %s_row_pos: new_row %0d after sample %0d, want %0d", tag, i, row_marks[i], (i + 1) * NC);
            end
        end
        tests++;
        if (n_ovl != 0 || n_coeff != 0) begin
            fails++;
            $display("FAIL %s_cmds: overlaps %0d coeff %0d, want 0 0", tag, n_ovl, n_coeff);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (col_idx !== 8'(NC - 1) || row_idx !== 8'(NR - 1) || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_final: col=%0d row=%0d busy=%b, want %0d %0d 0", tag, col_idx, row_idx, busy, NC - 1, NR - 1);
        end
    endtask

    task automatic test_coeff();
        int first_rdy;
        clear_stats();
        first_rdy = -1;
        @(posedge clk); #1; start = 1'b1; reload_coeff = 1'b1;
        @(posedge clk); #1; start = 1'b0; reload_coeff = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tests++;
                if (coeff_load_en !== 1'b1) begin
                    fails++;
                    $display("FAIL coeff_latency: coeff_load_en=%b one cycle after start, want 1", coeff_load_en);
                end
            end
            if (coeff_load_en) n_coeff++;
            if (src_ready && first_rdy < 0) begin
                first_rdy = k;
                break;
            end
        end
        tests++;
        if (first_rdy != 6) begin
            fails++;
            $display("FAIL coeff_ready: src_ready first at cycle %0d, want 6", first_rdy);
        end
        @(posedge clk); #1;
        run_frame(0, 0, 0, 2000);
        tests++;
        if (n_coeff != 1) begin
            fails++;
            $display("FAIL coeff_pulses: coeff_load_en pulses %0d, want 1", n_coeff);
        end
        tests++;
        if (n_done != 1 || issued.size() != NS || seq_err != 0) begin
            fails++;
            $display("FAIL coeff_frame: done=%0d samples=%0d errs=%0d, want 1 %0d 0", n_done, issued.size(), NS, seq_err);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad;
        clear_stats();
        bad = 0;
        @(posedge clk); #1; start = 1'b1; src_valid = 1'b1; force_wait = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (src_ready !== 1'b0 || sample_load_en || coeff_load_en || new_row || busy !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: %0d cycles with ready/command during modwait, want 0", bad);
        end
        force_wait = 1'b0;
        @(negedge clk);
        tests++;
        if (src_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: src_ready=%b when modwait falls, want 1", src_ready);
        end
        prev_hs = src_ready;
        prev_id = 0;
        cur_id  = src_ready ? 1 : 0;
        @(posedge clk); #1;
        run_frame(0, 0, 0, 2000);
        tests++;
        if (n_done != 1 || issued.size() != NS || seq_err != 0 || row_marks.size() != NR - 1) begin
            fails++;
            $display("FAIL bp_frame: done=%0d samples=%0d errs=%0d rows=%0d, want 1 %0d 0 %0d",
                     n_done, issued.size(), seq_err, row_marks.size(), NS, NR - 1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        bit rl;
        for (int f = 0; f < 3; f++) begin
            rl = 1'($urandom_range(0, 1));
            run_frame(1, rl, 2, 4000);
            tests++;
            if (n_done != 1 || issued.size() != NS || cur_id != NS || seq_err != 0 || n_ovl != 0) begin
                fails++;
                $display("FAIL rand_frame%0d: done=%0d samples=%0d acc=%0d errs=%0d ovl=%0d, want 1 %0d %0d 0 0",
                         f, n_done, issued.size(), cur_id, seq_err, n_ovl, NS, NS);
            end
            tests++;
            if (n_coeff != int'(rl)) begin
                fails++;
                $display("FAIL rand_coeff%0d: coeff pulses %0d, want %0d", f, n_coeff, rl);
            end
            for (int i = 0; i < issued.size(); i++) begin
                if (issued[i] != i) begin
                    tests++;
                    fails++;
                    $display("FAIL rand_order%0d: slot %0d got %0d", f, i, issued[i]);
                    break;
                end
            end
            repeat (2) @(negedge clk);
        end
    endtask

`ifdef CONV_SEQ_ABORT_EN
    task automatic test_abort();
        int ns, bad;
        ns = 0;
        bad = 0;
        @(posedge clk); #1; start = 1'b1; src_valid = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 500 && ns < 5; c++) begin
            @(negedge clk);
            if (sample_load_en) ns++;
            @(posedge clk); #1;
        end
        tests++;
        if (ns != 5) begin
            fails++;
            $display("FAIL abort_setup: saw %0d samples, want 5", ns);
        end
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        tests++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL abort_done: frame_done=%b after abort, want 1", frame_done);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (sample_load_en || coeff_load_en || new_row || busy || src_ready || frame_done) bad++;
        end
        tests++;
        if (bad != 0 || row_idx !== 8'd1) begin
            fails++;
            $display("FAIL abort_after: %0d active cycles, row=%0d, want 0 and 1", bad, row_idx);
        end
        src_valid = 1'b0;
    endtask
`endif

    initial begin
        start = 1'b0;
        reload_coeff = 1'b0;
        src_valid = 1'b0;
        force_wait = 1'b0;
`ifdef CONV_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_coeff();
        test_full_frame(0, "held");
        test_backpressure();
        test_full_frame(1, "bubble");
        test_random();
`ifdef CONV_SEQ_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
